// File: rtl/arrange.sv
// ---------------------------------------------------------------------------
// arrange: stable odd/even partitioner with a single registered stage.
//
// Ten WIDTH-bit values are accepted in parallel (A_in first ... J_in last).
// One cycle later they appear on A_out..J_out in a new order:
//   - the even values (bit 0 = 0) come first, in their original A->J order;
//   - the odd values follow, also in their original A->J order.
// Values are never altered. Only bit 0 is used to decide parity.
//
// Optional feature (compile-time macro ARRANGE_ODD_FIRST_EN):
//   When defined, the odd values fill the leading slots and the even values
//   fill the trailing slots. Both groups keep their A->J order. even_count
//   still counts the even values.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          asynchronous, active-high reset; clears every output
//   in_valid     sample the ten inputs on this edge
//   A_in..J_in   input values, A_in is the first position
//   out_valid    high for exactly one cycle per newly arranged set
//   A_out..J_out arranged values, A_out is the first slot
//   even_count   number of even values in the set on the outputs (0..10)
//
// When in_valid is low at an edge, out_valid drops and the data outputs and
// even_count keep their last values.
// ---------------------------------------------------------------------------
module arrange #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [WIDTH-1:0] C_in,
    input  logic [WIDTH-1:0] D_in,
    input  logic [WIDTH-1:0] E_in,
    input  logic [WIDTH-1:0] F_in,
    input  logic [WIDTH-1:0] G_in,
    input  logic [WIDTH-1:0] H_in,
    input  logic [WIDTH-1:0] I_in,
    input  logic [WIDTH-1:0] J_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic [WIDTH-1:0] C_out,
    output logic [WIDTH-1:0] D_out,
    output logic [WIDTH-1:0] E_out,
    output logic [WIDTH-1:0] F_out,
    output logic [WIDTH-1:0] G_out,
    output logic [WIDTH-1:0] H_out,
    output logic [WIDTH-1:0] I_out,
    output logic [WIDTH-1:0] J_out,
    output logic [3:0]       even_count
);

`ifdef ARRANGE_ODD_FIRST_EN
    localparam bit ODD_FIRST = 1'b1;
`else
    localparam bit ODD_FIRST = 1'b0;
`endif

    localparam int N = 10;

    logic [WIDTH-1:0] in_vec [N];
    logic [WIDTH-1:0] sorted [N];
    logic [3:0]       num_even;

    logic [WIDTH-1:0] data_d [N];
    logic [WIDTH-1:0] data_q [N];
    logic [3:0]       even_count_d, even_count_q;
    logic             out_valid_d, out_valid_q;

    assign in_vec[0] = A_in;
    assign in_vec[1] = B_in;
    assign in_vec[2] = C_in;
    assign in_vec[3] = D_in;
    assign in_vec[4] = E_in;
    assign in_vec[5] = F_in;
    assign in_vec[6] = G_in;
    assign in_vec[7] = H_in;
    assign in_vec[8] = I_in;
    assign in_vec[9] = J_in;

    // Partition: each group writes at its own running slot pointer. The
    // leading group starts at slot 0; the trailing group starts right after
    // the last slot the leading group will occupy.
    always_comb begin
        logic [3:0] even_idx;
        logic [3:0] odd_idx;

        // NOTE: every variable gets a default before any conditional update;
        // a path that leaves one unassigned would infer a latch.
        num_even = 4'd0;
        for (int i = 0; i < N; i++) begin
            sorted[i] = '0;
        end

        for (int i = 0; i < N; i++) begin
            if (!in_vec[i][0]) begin
                num_even = num_even + 4'd1;
            end
        end

        if (ODD_FIRST) begin
            odd_idx  = 4'd0;
            even_idx = 4'(N) - num_even;
        end else begin
            even_idx = 4'd0;
            odd_idx  = num_even;
        end

        for (int i = 0; i < N; i++) begin
            if (in_vec[i][0]) begin
                sorted[odd_idx] = in_vec[i];
                odd_idx         = odd_idx + 4'd1;
            end else begin
                sorted[even_idx] = in_vec[i];
                even_idx         = even_idx + 4'd1;
            end
        end
    end

    // Load a new set only when in_valid is high; otherwise hold the data.
    always_comb begin
        out_valid_d  = in_valid;
        even_count_d = even_count_q;
        for (int i = 0; i < N; i++) begin
            data_d[i] = data_q[i];
        end
        if (in_valid) begin
            even_count_d = num_even;
            for (int i = 0; i < N; i++) begin
                data_d[i] = sorted[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            even_count_q <= 4'd0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            out_valid_q  <= out_valid_d;
            even_count_q <= even_count_d;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign even_count = even_count_q;
    assign A_out      = data_q[0];
    assign B_out      = data_q[1];
    assign C_out      = data_q[2];
    assign D_out      = data_q[3];
    assign E_out      = data_q[4];
    assign F_out      = data_q[5];
    assign G_out      = data_q[6];
    assign H_out      = data_q[7];
    assign I_out      = data_q[8];
    assign J_out      = data_q[9];

endmodule

// File: tb/tb_arrange.sv
// ---------------------------------------------------------------------------
// tb_arrange: directed and random checks for the arrange partitioner.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point after the following edge.
// ---------------------------------------------------------------------------
module tb_arrange;

    localparam int WIDTH = 4;
    localparam int N     = 10;

    typedef logic [WIDTH-1:0] vec_t [N];

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_v  [N];
    logic [WIDTH-1:0] out_v [N];
    logic             out_valid;
    logic [3:0]       even_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arrange #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A_in       (in_v[0]),
        .B_in       (in_v[1]),
        .C_in       (in_v[2]),
        .D_in       (in_v[3]),
        .E_in       (in_v[4]),
        .F_in       (in_v[5]),
        .G_in       (in_v[6]),
        .H_in       (in_v[7]),
        .I_in       (in_v[8]),
        .J_in       (in_v[9]),
        .out_valid  (out_valid),
        .A_out      (out_v[0]),
        .B_out      (out_v[1]),
        .C_out      (out_v[2]),
        .D_out      (out_v[3]),
        .E_out      (out_v[4]),
        .F_out      (out_v[5]),
        .G_out      (out_v[6]),
        .H_out      (out_v[7]),
        .I_out      (out_v[8]),
        .J_out      (out_v[9]),
        .even_count (even_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_set(input string tag, input vec_t exp, input int exp_cnt, input logic exp_valid);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s slot%0d", tag, i), 32'(out_v[i]), 32'(exp[i]));
        end
        check({tag, " even_count"}, 32'(even_count), 32'(exp_cnt));
        check({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // Reference model: stable partition built by two separate passes.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   k = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++) begin
`ifdef ARRANGE_ODD_FIRST_EN
                if ((pass == 0) == (v[i][0] == 1'b1)) begin
`else
                if ((pass == 0) == (v[i][0] == 1'b0)) begin
`endif
                    r[k] = v[i];
                    k++;
                end
            end
        end
        return r;
    endfunction

    function automatic int count_even(input vec_t v);
        int c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i][0] == 1'b0) c++;
        end
        return c;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        for (int i = 0; i < N; i++) in_v[i] = v[i];
        in_valid = valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t mixed_in   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        vec_t odd_in     = '{4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1, 4'd1, 4'd3};
        vec_t even_in    = '{4'd14, 4'd12, 4'd10, 4'd8, 4'd6, 4'd4, 4'd2, 4'd0, 4'd0, 4'd2};
        vec_t hold_in    = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        vec_t dup_in     = '{4'd3, 4'd3, 4'd6, 4'd6, 4'd11, 4'd12, 4'd3, 4'd0, 4'd15, 4'd6};
        vec_t other_in   = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
        vec_t zero_v     = '{default: 4'd0};
`ifdef ARRANGE_ODD_FIRST_EN
        vec_t mixed_exp  = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8, 4'd0};
        vec_t hold_exp   = '{4'd9, 4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd4, 4'd2, 4'd0};
        vec_t dup_exp    = '{4'd3, 4'd3, 4'd11, 4'd3, 4'd15, 4'd6, 4'd6, 4'd12, 4'd0, 4'd6};
`else
        vec_t mixed_exp  = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd0, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
        vec_t hold_exp   = '{4'd8, 4'd6, 4'd4, 4'd2, 4'd0, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1};
        vec_t dup_exp    = '{4'd6, 4'd6, 4'd12, 4'd0, 4'd6, 4'd3, 4'd3, 4'd11, 4'd3, 4'd15};
`endif
        vec_t rnd;
        vec_t exp_data;
        int   exp_cnt;

        rst = 1'b1;
        drive(mixed_in, 1'b1);
        step();
        step();
        check_set("reset_state", zero_v, 0, 1'b0);

        // First edge with in_valid after reset release produces output.
        rst = 1'b0;
        drive(mixed_in, 1'b1);
        step();
        check_set("mixed", mixed_exp, 5, 1'b1);

        drive(odd_in, 1'b1);
        step();
        check_set("all_odd", odd_in, 0, 1'b1);
        drive(even_in, 1'b1);
        step();
        check_set("all_even", even_in, 10, 1'b1);

        drive(hold_in, 1'b1);
        step();
        check_set("hold_load", hold_exp, 5, 1'b1);
        drive(other_in, 1'b0);
        step();
        check_set("hold_1", hold_exp, 5, 1'b0);
        step();
        check_set("hold_2", hold_exp, 5, 1'b0);

        drive(dup_in, 1'b1);
        step();
        check_set("dups", dup_exp, 5, 1'b1);

        // Asynchronous reset mid-cycle with nonzero outputs held.
        drive(other_in, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_set("async_reset", zero_v, 0, 1'b0);
        step();
        check_set("reset_ignores_in", zero_v, 0, 1'b0);
        rst = 1'b0;
        drive(mixed_in, 1'b0);
        step();
        check_set("post_reset_idle", zero_v, 0, 1'b0);

        // Random regression against the model, with idle gaps.
        exp_data = zero_v;
        exp_cnt  = 0;
        for (int t = 0; t < 200; t++) begin
            logic v;
            for (int i = 0; i < N; i++) rnd[i] = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            drive(rnd, v);
            if (v) begin
                exp_data = model(rnd);
                exp_cnt  = count_even(rnd);
            end
            step();
            check_set($sformatf("rand%0d", t), exp_data, exp_cnt, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrange.md
Name: arrange

Overview:
- Stable odd/even partitioner for ten WIDTH-bit values presented in parallel on ports A..J.
- Each accepted set is re-emitted with all even values first, then all odd values. Relative input order is preserved within each group.
- Single registered stage, usable as a pipeline element in datapaths that must group values by parity.

Parameters:
- WIDTH, 4, bit width of every data input and output. Must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the ten inputs are sampled on this clock edge.
- A_in, B_in, C_in, D_in, E_in, F_in, G_in, H_in, I_in, J_in  input  WIDTH each  input values; positional order is A (first) through J (last).
- out_valid  output  1  high for exactly one cycle when a new arranged set is on the outputs.
- A_out, B_out, C_out, D_out, E_out, F_out, G_out, H_out, I_out, J_out  output  WIDTH each  arranged values; A_out is the first output slot.
- even_count  output  4  number of even values in the current output set, range 0..10.

Behaviour:
- Parity is bit 0 only: a value is even when bit 0 = 0, odd when bit 0 = 1. Upper bits are ignored for classification and passed through unchanged.
- Output ordering is a stable partition:
  - even inputs in A→J order fill A_out onward;
  - odd inputs in A→J order fill the remaining slots, ending at J_out.
- Every input value appears exactly once at the output. No values are dropped, duplicated or altered.
- Latency is 1 cycle. A set sampled at edge N (in_valid=1) appears on the outputs after edge N; out_valid=1 during that cycle.
- When in_valid=0 at an edge:
  - out_valid drops to 0;
  - data outputs and even_count hold their last values.
- Back-to-back sets (in_valid high every cycle) are accepted every cycle. There is no backpressure and no stall.
- even_count is registered together with the data, so it always describes the set currently on the outputs.
- Boundary cases:
  - All-even input: output equals input order, even_count=10.
  - All-odd input: output equals input order, even_count=0.
  - Duplicate values are kept in their original relative positions.
- Reset (rst=1, asynchronous, takes effect immediately without waiting for clk):
  - all *_out = 0, even_count = 0, out_valid = 0.
  - While rst is high, inputs are ignored.
  - A set sampled at the edge where reset asserts, or mid-pipeline, is discarded.
  - After rst deasserts, the first edge with in_valid=1 produces output on the following cycle.
- Implementation is purely combinational partition logic feeding one output register bank. No internal state beyond those registers.

Optional Feature:
- Macro: ARRANGE_ODD_FIRST_EN.
- Defined: odd values occupy the leading output slots and even values the trailing slots. Both groups remain stable (A→J order); even_count still counts even values.
- Undefined (default): evens first, as described in Behaviour.

Test Plan:
- Reset: assert rst between clock edges with nonzero outputs held → all outputs, even_count and out_valid go to 0 immediately, before the next clk edge.
- Mixed input: A..J = 1,2,3,4,5,6,7,8,9,0 with in_valid=1 → next cycle outputs 2,4,6,8,0,1,3,5,7,9, even_count=5, out_valid=1.
- All-odd then all-even, back-to-back:
  - 15,13,11,9,7,5,3,1,1,3 → same order, even_count=0;
  - next cycle 14,12,10,8,6,4,2,0,0,2 → same order, even_count=10.
  - out_valid stays high for both cycles.
- Hold: apply 9,8,7,6,5,4,3,2,1,0 (in_valid=1) → outputs 8,6,4,2,0,9,7,5,3,1, even_count=5. Then drop in_valid and change the inputs → outputs hold 8,6,4,2,0,9,7,5,3,1, out_valid=0.
- Duplicates and upper bits: A..J = 3,3,6,6,11,12,3,0,15,6 → 6,6,12,0,6,3,3,11,3,15, even_count=5.
- Random regression: 200 random sets checked against a reference partition model, including with ARRANGE_ODD_FIRST_EN defined (first mixed set → 1,3,5,7,9,2,4,6,8,0).
